// File: rtl/cpu_exec_pkg.sv
// Shared constants for the CPU execute stage: ALU op codes, operand mux
// selects, multiplier FSM states and flag bit positions.
package cpu_exec_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_PASS = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'hA;

    localparam logic [1:0] SEL_A_RD1   = 2'd0;
    localparam logic [1:0] SEL_A_RD2   = 2'd1;
    localparam logic [1:0] SEL_B_RD2   = 2'd0;
    localparam logic [1:0] SEL_B_IMM   = 2'd1;
    localparam logic [1:0] SEL_BYP_ALU = 2'd2;
    localparam logic [1:0] SEL_BYP_DM  = 2'd3;

    typedef enum logic {IDLE, MUL} ex_state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;

endpackage

// File: rtl/cpu_exec_stage_units.sv
// Execute-stage datapath units: the single-cycle ALU and the iterative
// shift-add multiplier (the latter only instantiated when EXEC_MUL_EN is set).
import cpu_exec_pkg::*;

module exec_alu #(
    parameter int DW = 16
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y,
    output logic [2:0]    flags
);
    logic c, v;

    always_comb begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                {c, y} = {1'b0, a} + {1'b0, b};
                v = (a[DW-1] == b[DW-1]) && (y[DW-1] != a[DW-1]);
            end
            // carry here is the borrow out of a - b
            OP_SUB: begin
                {c, y} = {1'b0, a} - {1'b0, b};
                v = (a[DW-1] != b[DW-1]) && (y[DW-1] != a[DW-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            // arithmetic doubling: overflow when the sign bit changes
            OP_SHL: begin
                y = a << 1;
                v = a[DW-1] ^ a[DW-2];
            end
            OP_SHR: begin
                y = a >> 1;
                c = a[0];
            end
            OP_PASS: y = b;
            default: y = '0;
        endcase
        flags         = '0;
        flags[FLAG_V] = v;
        flags[FLAG_C] = c;
        flags[FLAG_Z] = (y == '0);
    end
endmodule

module exec_mul_iter #(
    parameter int DW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] product
);
    localparam int CW = $clog2(DW);

    logic [2*DW-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_nx;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;

    always_comb begin
        acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = {{DW{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(DW - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (abort) begin
                busy_d = 1'b0;
            end else begin
                acc_d    = acc_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == '0) busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    // product is valid combinationally during the final (count zero) cycle
    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == '0);
    assign product = acc_nx;
endmodule

// File: rtl/cpu_exec_stage.sv
// CPU execute stage: operand select/bypass, immediate extension, ALU, branch
// target, registered EX outputs, sticky flags with IRQ save/restore.
// EXEC_MUL_EN enables the multi-cycle multiplier; otherwise MUL yields 0.
import cpu_exec_pkg::*;

module cpu_exec_stage #(
    parameter int DW          = 16,
    parameter int IW          = 6,
    parameter int AW          = 10,
    parameter int HANDLER_OFS = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [3:0]    alu_op,
    input  logic [1:0]    mux_alu_in1_select,
    input  logic [1:0]    mux_alu_in2_select,
    input  logic          ext_imm_sign,
    input  logic          flags_we,
    input  logic          br_en,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    input  logic [DW-1:0] bypass_from_alu,
    input  logic [DW-1:0] bypass_from_dm,
    input  logic [IW-1:0] instr_imm,
    input  logic [AW-1:0] instr_addr,
    input  logic [DW-1:0] pc_next_value,
    input  logic          flush,
    input  logic          irq_enter,
    input  logic          irq_return,
    output logic          stall_out,
    output logic          ex_valid,
    output logic [DW-1:0] ex_result,
    output logic [2:0]    ex_flags,
    output logic [2:0]    flags,
    output logic          branch_taken,
    output logic [DW-1:0] pc_branch_value,
    output logic [DW-1:0] ext_addr
);
    logic [DW-1:0] ext_imm, op_a, op_b, alu_y, fin_res;
    logic [2:0]    alu_f, fin_flags;
    logic          accept, is_mul, sc_fin, mul_fin, fin_we, fin_br, fin, upd;

    logic          ex_valid_q, ex_valid_d, branch_taken_q, branch_taken_d;
    logic [DW-1:0] ex_result_q, ex_result_d;
    logic [2:0]    ex_flags_q, ex_flags_d, flags_q, flags_d, saved_q, saved_d;

    always_comb begin
        ext_imm = ext_imm_sign ? DW'($signed(instr_imm)) : DW'(instr_imm);
        case (mux_alu_in1_select)
            SEL_A_RD1:   op_a = rf_rd1;
            SEL_A_RD2:   op_a = rf_rd2;
            SEL_BYP_ALU: op_a = bypass_from_alu;
            default:     op_a = bypass_from_dm;
        endcase
        case (mux_alu_in2_select)
            SEL_B_RD2:   op_b = rf_rd2;
            SEL_B_IMM:   op_b = ext_imm;
            SEL_BYP_ALU: op_b = bypass_from_alu;
            default:     op_b = bypass_from_dm;
        endcase
    end

    assign ext_addr        = DW'(instr_addr);
    assign pc_branch_value = pc_next_value + ext_imm + DW'(HANDLER_OFS);

    exec_alu #(.DW(DW)) u_alu (
        .op    (alu_op),
        .a     (op_a),
        .b     (op_b),
        .y     (alu_y),
        .flags (alu_f)
    );

    assign is_mul = (alu_op == OP_MUL);
    assign accept = in_valid && !stall_out && !flush;

`ifdef EXEC_MUL_EN
    ex_state_e       state_q, state_d;
    logic            pend_we_q, pend_we_d, pend_br_q, pend_br_d;
    logic            mul_start, mul_busy, mul_done;
    logic [2*DW-1:0] mul_prod;

    assign mul_start = accept && is_mul;

    exec_mul_iter #(.DW(DW)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .abort   (flush),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign stall_out = mul_busy;
    assign sc_fin    = accept && !is_mul;
    assign mul_fin   = (state_q == MUL) && mul_done && !flush;

    // flags_we / br_en belong to the MUL instruction, so hold them until it retires
    always_comb begin
        state_d   = state_q;
        pend_we_d = pend_we_q;
        pend_br_d = pend_br_q;
        case (state_q)
            IDLE: if (mul_start) begin
                state_d   = MUL;
                pend_we_d = flags_we;
                pend_br_d = br_en;
            end
            MUL:     if (flush || mul_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pend_we_q <= 1'b0;
            pend_br_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_we_q <= pend_we_d;
            pend_br_q <= pend_br_d;
        end
    end

    always_comb begin
        fin_res   = alu_y;
        fin_flags = alu_f;
        fin_we    = flags_we;
        fin_br    = br_en;
        if (mul_fin) begin
            fin_res           = mul_prod[DW-1:0];
            fin_flags         = '0;
            fin_flags[FLAG_Z] = (mul_prod[DW-1:0] == '0);
            fin_flags[FLAG_C] = |mul_prod[2*DW-1:DW];
            fin_we            = pend_we_q;
            fin_br            = pend_br_q;
        end
    end
`else
    assign stall_out = 1'b0;
    assign sc_fin    = accept;
    assign mul_fin   = 1'b0;

    always_comb begin
        fin_res   = alu_y;
        fin_flags = alu_f;
        fin_we    = flags_we;
        fin_br    = br_en;
        if (is_mul) begin
            fin_res   = '0;
            fin_flags = 3'b001;
        end
    end
`endif

    // irq_return restores over a same-cycle update; irq_enter masks irq_return
    always_comb begin
        fin            = sc_fin || mul_fin;
        upd            = fin && fin_we;
        ex_valid_d     = fin;
        ex_result_d    = fin ? fin_res : ex_result_q;
        ex_flags_d     = fin ? fin_flags : ex_flags_q;
        branch_taken_d = fin && fin_br && fin_flags[FLAG_Z];
        saved_d        = saved_q;
        flags_d        = flags_q;
        if (irq_enter) saved_d = upd ? fin_flags : flags_q;
        if (irq_return && !irq_enter) flags_d = saved_q;
        else if (upd)                 flags_d = fin_flags;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_result_q    <= '0;
            ex_flags_q     <= '0;
            flags_q        <= '0;
            saved_q        <= '0;
            branch_taken_q <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_result_q    <= ex_result_d;
            ex_flags_q     <= ex_flags_d;
            flags_q        <= flags_d;
            saved_q        <= saved_d;
            branch_taken_q <= branch_taken_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_result    = ex_result_q;
    assign ex_flags     = ex_flags_q;
    assign flags        = flags_q;
    assign branch_taken = branch_taken_q;
endmodule

// File: doc/cpu_exec_stage.md
Name: cpu_exec_stage

Overview:
- Parametrised execute stage for the interrupt-capable CPU: operand select with bypass, immediate and address extension, ALU, branch-target adder.
- Adds a registered EX output stage, a sticky flag register with interrupt save/restore, an iterative multi-cycle multiplier with stall handshake, and a synchronous flush.
- Sits between decode/control FSM and data-memory stage; drives EX/MEM pipeline register contents.

Parameters:
- DW, 16, datapath width (≥8).
- IW, 6, instruction immediate width (<DW).
- AW, 10, instruction address field width (≤DW).
- HANDLER_OFS, 5, constant added to branch target (interrupt-handler epilogue length).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decode presents an instruction.
- alu_op  in  4  operation code; 4'hA = MUL (multi-cycle), others single-cycle.
- mux_alu_in1_select  in  2  0 rf_rd1, 1 rf_rd2, 2 bypass_from_alu, 3 bypass_from_dm.
- mux_alu_in2_select  in  2  0 rf_rd2, 1 ext_imm, 2 bypass_from_alu, 3 bypass_from_dm.
- ext_imm_sign  in  1  1 sign-extend, 0 zero-extend instr_imm.
- flags_we  in  1  instruction updates flag register.
- br_en  in  1  instruction is a conditional branch on zero.
- rf_rd1, rf_rd2, bypass_from_alu, bypass_from_dm  in  DW each  operand sources.
- instr_imm  in  IW  immediate field.
- instr_addr  in  AW  address field.
- pc_next_value  in  DW  PC+1 of the instruction.
- flush  in  1  kill current and in-flight operation.
- irq_enter  in  1  save flags on interrupt entry.
- irq_return  in  1  restore flags on handler return.
- stall_out  out  1  stage cannot accept; decode holds.
- ex_valid  out  1  ex_result/ex_flags valid.
- ex_result  out  DW  registered result.
- ex_flags  out  3  {overflow, carry, zero} of ex_result.
- flags  out  3  architectural flag register.
- branch_taken  out  1  registered: br_en && zero.
- pc_branch_value  out  DW  combinational pc_next_value + ext_imm + HANDLER_OFS, mod 2^DW.
- ext_addr  out  DW  zero-extended instr_addr.

Behaviour:
- Reset:
  - state IDLE; ex_valid, ex_result, ex_flags, flags, saved flags, branch_taken, counter all 0.
  - reset overrides every other input.
- Accept: in_valid && !stall_out && !flush.
- Single-cycle op: result and flags registered at the accept edge; ex_valid=1 for one cycle (latency 1).
- No accept (no MUL completing): ex_valid=0; ex_result holds its previous value.
- MUL state machine, IDLE → MUL → IDLE:
  - On accept, latch both operands; counter=DW-1; stall_out=1 combinationally while in MUL.
  - One shift-add iteration per cycle; after the counter=0 cycle, ex_result = low DW bits of the product and ex_valid pulses; return to IDLE.
  - Latency DW+1 from the accept edge; accept is possible again in the cycle ex_valid is high.
  - MUL flags: zero = low half 0; carry = high half ≠0; overflow = 0.
- Flags:
  - flags <= ex_flags on completion when flags_we was set (latched at accept).
  - irq_return: flags <= saved, taking priority over a completing update.
  - irq_enter: saved <= current flags, plus the completing update if one occurs that cycle.
  - irq_enter and irq_return together: irq_enter only.
- flush:
  - Next cycle ex_valid=0, branch_taken=0, state IDLE; the MUL is aborted with no flag update.
  - Flush beats accept in the same cycle.
- Wrap: all adds are modulo 2^DW; sign extension replicates instr_imm[IW-1].

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: MUL behaves as above.
- Undefined: no multiplier hardware; alu_op 4'hA completes in 1 cycle with ex_result=0, ex_flags=3'b001; stall_out is tied 0.

Decomposition:
- Package cpu_exec_pkg: op-code constants (OP_MUL=4'hA, ALU ops), mux select constants, state enum {IDLE, MUL}, flag bit indices.
- Sub-module: exec_mul_iter (operands, start, busy, done, product), instantiated only under EXEC_MUL_EN.
- The ALU is a combinational instance parametrised by DW.

Test Plan:
- Reset mid-MUL: start MUL 3×4, assert reset at cycle 5 → next cycle state IDLE, stall_out=0, ex_valid=0, flags=0.
- ADD rf_rd1=16'hFFFF, imm=6'h01 with ext_imm_sign=0, flags_we → next cycle ex_result=0, zero=1, carry=1, flags=3'b011.
- MUL 16'h0100×16'h0100, DW=16 → stall_out high 16 cycles; ex_valid at cycle 17 with ex_result=0, carry=1, zero=1.
- Branch: pc_next=16'h0010, imm=6'h3E signed → pc_branch_value=16'h0013; br_en with zero result → branch_taken=1 next cycle.
- Flush at MUL cycle 4 with flags_we → no ex_valid, flags unchanged, the instruction presented next cycle is accepted.
- irq_enter with flags=3'b101, then ADD changes flags, then irq_return → flags=3'b101; irq_return coincident with a completing update → saved value wins.
